// File: rtl/tmr_fault_irq_gen.sv
// Fault collector for the TMR voters: classifies voter disagreements as transient or
// persistent, keeps sticky W1C status, and raises one level interrupt with a re-arm hold-off.
module tmr_fault_irq_gen #(
  parameter int NUM_SRC     = 5,
  parameter int CNT_W       = 8,
  parameter int PERSIST_CYC = 4,
  parameter int HOLDOFF     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         fault_i,
  input  logic                       irq_en_i,
  input  logic                       clr_i,
  input  logic [NUM_SRC-1:0]         clr_mask_i,
  input  logic                       cnt_clr_i,
  output logic                       irq_o,
  output logic [NUM_SRC-1:0]         status_o,
  output logic [NUM_SRC-1:0]         perm_o,
  output logic [CNT_W-1:0]           fault_cnt_o,
  output logic [$clog2(NUM_SRC)-1:0] first_src_o
);

  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int RUN_W = $clog2(PERSIST_CYC + 1);
  localparam int POP_W = $clog2(NUM_SRC + 1);
  localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
  localparam int TMR_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(PERSIST_CYC);

  typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} state_t;

  state_t             state;
  logic [TMR_W-1:0]   timer;
  logic [NUM_SRC-1:0] fault_q;
  logic [RUN_W-1:0]   run_q    [NUM_SRC];
  logic [RUN_W-1:0]   run_next [NUM_SRC];

  logic [NUM_SRC-1:0] episode;
  logic [NUM_SRC-1:0] clr_vec;
  logic [NUM_SRC-1:0] status_next;
  logic [NUM_SRC-1:0] perm_next;
  logic [POP_W-1:0]   ep_cnt;
  logic [SUM_W-1:0]   cnt_sum;
  logic [CNT_W-1:0]   cnt_next;
  logic [SRC_W-1:0]   low_idx;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    episode     = fault_i & ~fault_q;
    clr_vec     = clr_i ? clr_mask_i : '0;
    status_next = (status_o & ~clr_vec) | episode;
    ep_cnt      = '0;
    low_idx     = '0;
    perm_next   = perm_o;
    for (int i = 0; i < NUM_SRC; i++) begin
      // NOTE: blocking '=' here builds a combinational chain; the ff blocks below use '<='.
      ep_cnt = ep_cnt + POP_W'(episode[i]);
      if (!fault_i[i])
        run_next[i] = '0;
      else if (run_q[i] == RUN_MAX)
        run_next[i] = run_q[i];
      else
        run_next[i] = run_q[i] + 1'b1;
      // A source still asserting cannot have its permanent flag cleared.
      if (run_next[i] == RUN_MAX)
        perm_next[i] = 1'b1;
      else if (clr_vec[i] && !fault_i[i])
        perm_next[i] = 1'b0;
    end
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (episode[i]) low_idx = SRC_W'(i);
    end
    cnt_sum  = SUM_W'(cnt_clr_i ? '0 : fault_cnt_o) + SUM_W'(ep_cnt);
    cnt_next = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q     <= '0;
      status_o    <= '0;
      perm_o      <= '0;
      fault_cnt_o <= '0;
      first_src_o <= '0;
      // NOTE: the run-length array is a handful of flops, not RAM, so it is reset like any register.
      for (int i = 0; i < NUM_SRC; i++) run_q[i] <= '0;
    end else begin
      fault_q     <= fault_i;
      status_o    <= status_next;
      perm_o      <= perm_next;
      fault_cnt_o <= cnt_next;
      run_q       <= run_next;
      if (status_o == '0 && status_next != '0) first_src_o <= low_idx;
    end
  end

  // irq_o is registered from the next-state decision, so it rises with the status bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      irq_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (status_next != '0 && irq_en_i) begin
            state <= ACTIVE;
            irq_o <= 1'b1;
          end
        end
        ACTIVE: begin
          if (!irq_en_i) begin
            state <= IDLE;
            irq_o <= 1'b0;
          end else if (status_next == '0) begin
            irq_o <= 1'b0;
            if (HOLDOFF == 0) begin
              state <= IDLE;
            end else begin
              state <= HOLD;
              timer <= TMR_W'(HOLDOFF);
            end
          end
        end
        HOLD: begin
          if (timer <= TMR_W'(1)) begin
            timer <= '0;
            if (status_next != '0 && irq_en_i) begin
              state <= ACTIVE;
              irq_o <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          irq_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tmr_fault_irq_gen.sv
// Bench for tmr_fault_irq_gen: directed vector table, hand-written hold-off/reset sequences,
// then random stimulus against a behavioural model. A CNT_W=2 copy exercises saturation.
module tb_tmr_fault_irq_gen;
  localparam int N  = 5;
  localparam int PC = 4;
  localparam int HO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] fault, clr_mask;
  logic         irq_en, clr, cnt_clr;
  logic         irq, irq_s;
  logic [N-1:0] status, perm, status_s, perm_s;
  logic [7:0]   fault_cnt;
  logic [1:0]   fault_cnt_s;
  logic [2:0]   first_src, first_src_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tmr_fault_irq_gen #(.NUM_SRC(N), .CNT_W(8), .PERSIST_CYC(PC), .HOLDOFF(HO)) dut (
    .clk(clk), .rst(rst), .fault_i(fault), .irq_en_i(irq_en), .clr_i(clr),
    .clr_mask_i(clr_mask), .cnt_clr_i(cnt_clr), .irq_o(irq), .status_o(status),
    .perm_o(perm), .fault_cnt_o(fault_cnt), .first_src_o(first_src));

  tmr_fault_irq_gen #(.NUM_SRC(N), .CNT_W(2), .PERSIST_CYC(PC), .HOLDOFF(HO)) dut_sat (
    .clk(clk), .rst(rst), .fault_i(fault), .irq_en_i(irq_en), .clr_i(clr),
    .clr_mask_i(clr_mask), .cnt_clr_i(cnt_clr), .irq_o(irq_s), .status_o(status_s),
    .perm_o(perm_s), .fault_cnt_o(fault_cnt_s), .first_src_o(first_src_s));

  typedef struct {
    logic [N-1:0] f;
    logic         en;
    logic         c;
    logic [N-1:0] m;
    logic         cc;
    logic         e_irq;
    logic [N-1:0] e_st;
    logic [N-1:0] e_pm;
    int           e_cnt;
    int           e_cnt2;
    int           e_first;
  } vec_t;

  vec_t tbl[17];

  // Behavioural reference state
  logic [N-1:0] m_status, m_perm, m_prev;
  int           m_run[N];
  int           m_cnt, m_cnt2, m_first, m_hold;
  logic         m_irq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [N-1:0] f, input logic en, input logic c,
                       input logic [N-1:0] m, input logic cc);
    fault = f; irq_en = en; clr = c; clr_mask = m; cnt_clr = cc;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " irq"}, 32'(irq), 32'd0);
    check({tag, " status"}, 32'(status), 32'd0);
    check({tag, " perm"}, 32'(perm), 32'd0);
    check({tag, " cnt"}, 32'(fault_cnt), 32'd0);
    check({tag, " first"}, 32'(first_src), 32'd0);
    check({tag, " cnt_sat"}, 32'(fault_cnt_s), 32'd0);
  endtask

  task automatic do_reset();
    drive('0, 1'b0, 1'b0, '0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic model_reset();
    m_status = '0; m_perm = '0; m_prev = '0;
    m_cnt = 0; m_cnt2 = 0; m_first = 0; m_hold = 0; m_irq = 1'b0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
  endtask

  // One clock edge of the specified behaviour, from the inputs about to be sampled.
  task automatic model_step(input logic [N-1:0] f, input logic en, input logic c,
                            input logic [N-1:0] m, input logic cc);
    int pop = 0;
    int low = -1;
    logic [N-1:0] ep, nst;
    ep = f & ~m_prev;
    for (int i = 0; i < N; i++) begin
      if (ep[i]) begin
        pop++;
        if (low < 0) low = i;
      end
    end
    nst = (m_status & ~(c ? m : '0)) | ep;
    for (int i = 0; i < N; i++) begin
      m_run[i] = f[i] ? ((m_run[i] < PC) ? m_run[i] + 1 : PC) : 0;
      if (m_run[i] == PC) m_perm[i] = 1'b1;
      else if (c && m[i] && !f[i]) m_perm[i] = 1'b0;
    end
    m_cnt  = (cc ? 0 : m_cnt) + pop;
    m_cnt2 = (cc ? 0 : m_cnt2) + pop;
    if (m_cnt > 255) m_cnt = 255;
    if (m_cnt2 > 3) m_cnt2 = 3;
    if (m_status == '0 && nst != '0) m_first = low;
    if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) m_irq = (nst != '0) && en;
    end else if (!m_irq) begin
      m_irq = (nst != '0) && en;
    end else if (!en) begin
      m_irq = 1'b0;
    end else if (nst == '0) begin
      m_irq = 1'b0;
      m_hold = HO;
    end
    m_status = nst;
    m_prev = f;
  endtask

  initial begin
    // f, en, clr, mask, cnt_clr | irq, status, perm, cnt, cnt(CNT_W=2), first
    tbl[0]  = '{5'b00100, 1, 0, 5'b00000, 0, 1, 5'b00100, 5'b00000, 1, 1, 2};
    tbl[1]  = '{5'b00000, 0, 0, 5'b00000, 0, 0, 5'b00100, 5'b00000, 1, 1, 2};
    tbl[2]  = '{5'b00000, 1, 0, 5'b00000, 0, 1, 5'b00100, 5'b00000, 1, 1, 2};
    tbl[3]  = '{5'b00000, 0, 1, 5'b11111, 0, 0, 5'b00000, 5'b00000, 1, 1, 2};
    tbl[4]  = '{5'b00001, 1, 0, 5'b00000, 0, 1, 5'b00001, 5'b00000, 2, 2, 0};
    tbl[5]  = '{5'b00001, 1, 0, 5'b00000, 0, 1, 5'b00001, 5'b00000, 2, 2, 0};
    tbl[6]  = '{5'b00001, 1, 0, 5'b00000, 0, 1, 5'b00001, 5'b00000, 2, 2, 0};
    tbl[7]  = '{5'b00001, 1, 0, 5'b00000, 0, 1, 5'b00001, 5'b00001, 2, 2, 0};
    tbl[8]  = '{5'b00001, 0, 1, 5'b00001, 0, 0, 5'b00000, 5'b00001, 2, 2, 0};
    tbl[9]  = '{5'b00001, 0, 0, 5'b00000, 0, 0, 5'b00000, 5'b00001, 2, 2, 0};
    tbl[10] = '{5'b00000, 0, 1, 5'b00001, 0, 0, 5'b00000, 5'b00000, 2, 2, 0};
    tbl[11] = '{5'b10010, 1, 0, 5'b00000, 0, 1, 5'b10010, 5'b00000, 4, 3, 1};
    tbl[12] = '{5'b10010, 1, 1, 5'b00010, 0, 1, 5'b10000, 5'b00000, 4, 3, 1};
    tbl[13] = '{5'b00000, 1, 0, 5'b00000, 0, 1, 5'b10000, 5'b00000, 4, 3, 1};
    tbl[14] = '{5'b00010, 1, 1, 5'b00010, 0, 1, 5'b10010, 5'b00000, 5, 3, 1};
    tbl[15] = '{5'b00000, 1, 0, 5'b00000, 0, 1, 5'b10010, 5'b00000, 5, 3, 1};
    tbl[16] = '{5'b01000, 1, 0, 5'b00000, 1, 1, 5'b11010, 5'b00000, 1, 1, 1};

    rst = 1'b1;
    drive('0, 1'b0, 1'b0, '0, 1'b0);
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 17; k++) begin
      drive(tbl[k].f, tbl[k].en, tbl[k].c, tbl[k].m, tbl[k].cc);
      step();
      check($sformatf("vec%0d irq", k), 32'(irq), 32'(tbl[k].e_irq));
      check($sformatf("vec%0d status", k), 32'(status), 32'(tbl[k].e_st));
      check($sformatf("vec%0d perm", k), 32'(perm), 32'(tbl[k].e_pm));
      check($sformatf("vec%0d cnt", k), 32'(fault_cnt), 32'(tbl[k].e_cnt));
      check($sformatf("vec%0d cnt_sat", k), 32'(fault_cnt_s), 32'(tbl[k].e_cnt2));
      check($sformatf("vec%0d first", k), 32'(first_src), 32'(tbl[k].e_first));
    end

    // Clear everything, then an episode on bit 3 two cycles later waits out the hold-off.
    drive(5'b00000, 1'b1, 1'b1, 5'b11111, 1'b0);
    step();
    check("holdoff clr irq", 32'(irq), 32'd0);
    check("holdoff clr status", 32'(status), 32'd0);
    for (int j = 1; j <= HO; j++) begin
      drive((j == 2) ? 5'b01000 : 5'b00000, 1'b1, 1'b0, '0, 1'b0);
      step();
      check($sformatf("holdoff irq c%0d", j), 32'(irq), 32'(j == HO));
      if (j == 2) begin
        check("holdoff status", 32'(status), 32'b01000);
        check("holdoff first", 32'(first_src), 32'd3);
      end
    end
    check("holdoff cnt", 32'(fault_cnt), 32'd2);
    check("holdoff cnt_sat", 32'(fault_cnt_s), 32'd2);

    // Swap bit 3 for bits 0 and 2 in one cycle: status never empties, irq stays high.
    drive(5'b00101, 1'b1, 1'b1, 5'b01000, 1'b0);
    step();
    check("swap status", 32'(status), 32'b00101);
    check("swap irq", 32'(irq), 32'd1);
    check("swap first", 32'(first_src), 32'd3);
    check("swap cnt", 32'(fault_cnt), 32'd4);
    check("swap cnt_sat", 32'(fault_cnt_s), 32'd3);
    #2 rst = 1'b1;
    #1 check_all_zero("async rst active");
    @(negedge clk);
    drive('0, 1'b0, 1'b0, '0, 1'b0);
    rst = 1'b0;
    step();
    check_all_zero("post rst");

    // Reset during hold-off must abort it: the next episode raises irq at once.
    drive(5'b00001, 1'b1, 1'b0, '0, 1'b0);
    step();
    check("pre-hold irq", 32'(irq), 32'd1);
    drive(5'b00000, 1'b1, 1'b1, 5'b11111, 1'b0);
    step();
    check("in-hold irq", 32'(irq), 32'd0);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(5'b00010, 1'b1, 1'b0, '0, 1'b0);
    step();
    check("hold abort irq", 32'(irq), 32'd1);
    check("hold abort first", 32'(first_src), 32'd1);

    // Random phase against the behavioural model.
    do_reset();
    model_reset();
    begin
      logic [N-1:0] f_r = '0;
      for (int n = 0; n < 600; n++) begin
        logic [N-1:0] flip, m_r;
        logic en_r, c_r, cc_r;
        flip = '0;
        for (int b = 0; b < N; b++) flip[b] = ($urandom_range(0, 3) == 0);
        f_r  = f_r ^ flip;
        en_r = ($urandom_range(0, 7) != 0);
        c_r  = ($urandom_range(0, 5) == 0);
        m_r  = N'($urandom);
        cc_r = ($urandom_range(0, 19) == 0);
        drive(f_r, en_r, c_r, m_r, cc_r);
        model_step(f_r, en_r, c_r, m_r, cc_r);
        step();
        check($sformatf("rnd%0d irq", n), 32'(irq), 32'(m_irq));
        check($sformatf("rnd%0d status", n), 32'(status), 32'(m_status));
        check($sformatf("rnd%0d perm", n), 32'(perm), 32'(m_perm));
        check($sformatf("rnd%0d cnt", n), 32'(fault_cnt), 32'(m_cnt));
        check($sformatf("rnd%0d cnt_sat", n), 32'(fault_cnt_s), 32'(m_cnt2));
        if (m_status != '0)
          check($sformatf("rnd%0d first", n), 32'(first_src), 32'(m_first));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tmr_fault_irq_gen.md
Name: tmr_fault_irq_gen

Overview:
- Collects the per-output disagreement flags from the TMR voters of the triplicated blocks.
- Classifies each disagreement as a transient or a persistent fault and keeps sticky status.
- Drives one level-triggered interrupt line into the core's irq_i vector. This makes it the transmitter side of the irq_i interface that the fault-tolerant interrupt controller receives.
- Software reads status, clears it with a write-one-to-clear pulse, and can re-arm after a hold-off.

Parameters:
NUM_SRC, 5, number of voter fault inputs (one per voter)
CNT_W, 8, width of the saturating fault-event counter
PERSIST_CYC, 4, consecutive asserted cycles after which a source is flagged permanent (>=2)
HOLDOFF, 8, cycles irq_o is forced low after a clear that empties status (0 = no hold-off)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
fault_i  in  NUM_SRC  voter detected flags, synchronous to clk
irq_en_i  in  1  interrupt enable
clr_i  in  1  single-cycle clear strobe
clr_mask_i  in  NUM_SRC  bits to clear when clr_i=1 (W1C)
cnt_clr_i  in  1  clears fault_cnt_o
irq_o  out  1  level interrupt, connected to one irq_i bit
status_o  out  NUM_SRC  sticky fault-seen bits
perm_o  out  NUM_SRC  sticky persistent-fault bits
fault_cnt_o  out  CNT_W  saturating count of fault episodes
first_src_o  out  $clog2(NUM_SRC)  source of the first fault since status was last empty

Behaviour:
- Reset (async, rst=1): all outputs 0, all internal registers 0, FSM in IDLE. Reset mid-hold-off or mid-run aborts immediately.
- Edge detection:
  - fault_q holds fault_i registered.
  - An episode on bit i is fault_i[i]=1 & fault_q[i]=0 at a clock edge.
- status_o:
  - status_o[i] is set on an episode on bit i, visible after that edge.
  - It is cleared when clr_i & clr_mask_i[i].
  - Set beats clear in the same cycle.
- Run-length counter per source:
  - Increments while fault_i[i]=1 and saturates at PERSIST_CYC.
  - Resets to 0 when fault_i[i]=0.
  - Reaching PERSIST_CYC sets perm_o[i], so the bit rises at the edge on which fault_i[i] has been sampled high PERSIST_CYC times in a row.
  - perm_o[i] clears via clr_i & clr_mask_i[i] only if fault_i[i]=0 that cycle; otherwise it stays set.
- fault_cnt_o:
  - Adds popcount(episodes) each cycle and saturates at 2^CNT_W-1 (no wrap).
  - cnt_clr_i zeroes it; if episodes occur in the same cycle, the result equals that cycle's popcount.
- first_src_o:
  - Captured when status goes from all-zero to non-zero.
  - Holds the lowest index among simultaneous episodes.
  - Held until status is empty again; not cleared by clear.
- IRQ FSM (irq_o registered, driven from next-state):
  - IDLE, irq_o=0. Go to ACTIVE when status_next!=0 & irq_en_i.
  - ACTIVE, irq_o=1.
    - If irq_en_i=0, go to IDLE.
    - If status_next==0 due to clear, go to HOLDOFF with timer=HOLDOFF, or to IDLE if HOLDOFF=0.
  - HOLDOFF, irq_o=0. The timer decrements each cycle and status may still set. When the timer reaches 0, go to ACTIVE if status!=0 & irq_en_i, else IDLE.
- Latency: an episode at edge k with irq_en_i=1 in IDLE gives irq_o=1 after edge k, in the same cycle status_o shows it.
- A partial clear leaving status!=0 keeps irq_o=1.
- irq_en_i going 1 while status!=0 in IDLE asserts irq_o at the next edge.

Test Plan:
- Reset: assert rst mid-ACTIVE with status=5'b00101 -> all outputs 0 immediately (async), FSM IDLE.
- Transient: fault_i[2]=1 for 1 cycle, en=1 -> status_o=5'b00100, perm_o=0, fault_cnt_o=1, first_src_o=2, irq_o=1 at the same edge.
- Persistent: fault_i[0]=1 for 6 cycles -> perm_o[0]=1 after the 4th sampled edge; fault_cnt_o=1. Clear with mask bit0 while still asserted -> status[0]=0, perm_o[0] stays 1.
- Simultaneous: fault_i=5'b10010 rising together -> fault_cnt_o+=2, first_src_o=1. Clear with mask 5'b00010 -> status=5'b10000, irq_o stays 1.
- Hold-off: clear all with HOLDOFF=8, new episode on bit 3 two cycles later -> status[3]=1 but irq_o=0 until the timer expires, then irq_o=1.
- Saturation and conflicts: CNT_W=2, 5 separate episodes -> fault_cnt_o=3. Clear and episode on the same bit in the same cycle -> bit remains set. cnt_clr_i with 1 episode -> count=1.
